jogador_automatico: RTL
=======================

// Module: jogador_automatico
// PURPOSE
//  Automatic player for the memory game (circuito_jogo_base): the player end of the
//  jogar/botoes/ganhou/perdeu/pronto interface. Pulses jogar, then replays the expected
//  sequence round by round (round r presses entries 0..r), one button per press.
//  Optional single-error injection at a chosen (rodada, jogada). Sits beside the game on
//  the FPGA as a self-test stimulus source, and in benches as a synthesizable player.
// PARAMETERS
//  NUM_RODADAS   16  rounds for a full game; last round index = NUM_RODADAS-1
//  JOGAR_CYCLES   5  cycles jogar is held high
//  START_WAIT    10  idle cycles after jogar falls, before the first press
//  PRESS_CYCLES   5  cycles each button pattern is held
//  GAP_CYCLES     5  cycles botoes=0 after each press
// PORTS
//  clock        in   1  system clock, rising edge
//  reset        in   1  asynchronous, active-high
//  iniciar      in   1  level; sampled high in OCIOSO or FIM starts a game
//  erro_en      in   1  enable error injection
//  erro_rodada  in   4  round index of injected error
//  erro_jogada  in   4  play index of injected error
//  ganhou       in   1  from game: win
//  perdeu       in   1  from game: loss
//  jogar        out  1  to game: start request
//  botoes       out  4  to game: one-hot button pattern
//  ativo        out  1  game in progress (not OCIOSO/FIM)
//  fim          out  1  game over
//  resultado    out  1  valid with fim: 1=ganhou seen, 0=perdeu seen or sequence exhausted
//  db_rodada    out  4  current round index
//  db_estado    out  3  state encoding
// BEHAVIOUR
//  - All outputs registered. Reset: state OCIOSO, jogar=0, botoes=0, ativo=0, fim=0,
//    resultado=0, rodada=0, jogada=0, timer=0. Reset mid-game aborts immediately.
//  - States (db_estado): OCIOSO=0, JOGAR=1, ESPERA=2, PRESSIONA=3, SOLTA=4, PROXIMA=5, FIM=6.
//  - OCIOSO: iniciar=1 -> JOGAR; clears rodada, jogada, fim, resultado.
//  - JOGAR: jogar=1 for exactly JOGAR_CYCLES cycles -> ESPERA.
//  - ESPERA: botoes=0 for START_WAIT cycles -> PRESSIONA.
//  - PRESSIONA: botoes=rom[jogada] for exactly PRESS_CYCLES cycles -> SOLTA.
//    If erro_en && rodada==erro_rodada && jogada==erro_jogada: botoes=rotl1(rom[jogada])
//    (always one-hot, always wrong). erro_* sampled every cycle, not latched.
//  - SOLTA: botoes=0 for GAP_CYCLES cycles -> PROXIMA.
//  - PROXIMA (1 cycle, botoes=0): jogada<rodada -> jogada++, PRESSIONA;
//    jogada==rodada && rodada<NUM_RODADAS-1 -> rodada++, jogada=0, PRESSIONA;
//    rodada==NUM_RODADAS-1 -> FIM, resultado=0 (game failed to declare a win).
//  - ganhou or perdeu sampled high in ESPERA/PRESSIONA/SOLTA/PROXIMA -> FIM next edge;
//    resultado=ganhou (ganhou wins if both high); botoes and jogar forced 0 that edge.
//    Ignored in OCIOSO, JOGAR and FIM.
//  - FIM: fim=1, ativo=0, outputs 0, rodada held for debug; iniciar=1 -> JOGAR (restart).
//  - Timer: single down-counter, width $clog2(max timing param)+1; reloaded on each
//    state entry with param-1; leave state when timer==0. Params >=1 required.
//  - rodada/jogada 4 bits; never wrap (bounded by NUM_RODADAS<=16).
// STRUCTURE
//  - Package jogo_pkg: state enum/localparams, button one-hot constants, ROM contents
//    (default sequence 0001,0010,0100,1000 repeating) shared with the game's memory.
//  - Sub-module sequencia_rom: 16x4 combinational ROM, addr=jogada, data=expected button.
//  - Top: FSM + timer + rodada/jogada counters + error mux.
// TESTING
//  - Reset, iniciar=1 one cycle, game stub never asserts results -> jogar high 5 cycles,
//    first botoes=0001 after 10 idle cycles, held 5; 136 presses total; fim=1, resultado=0.
//  - Stub asserts ganhou after press 136 -> fim=1, resultado=1 within 1 cycle, botoes=0.
//  - erro_en=1, erro_rodada=4, erro_jogada=2 -> that press is 1000 (not 0100); stub
//    asserts perdeu -> fim=1, resultado=0, db_rodada=4.
//  - reset asserted during PRESSIONA of round 3 -> same cycle botoes=0, state OCIOSO,
//    db_rodada=0; iniciar afterwards restarts from round 0.
//  - ganhou and perdeu together in SOLTA -> resultado=1; iniciar held in FIM -> new jogar pulse.
//  - Timing audit: each press exactly PRESS_CYCLES, each gap GAP_CYCLES+1 (incl. PROXIMA).

Source files
------------

// File: rtl/jogo_pkg.sv
// Shared definitions for the memory game and its automatic player: state encoding,
// one-hot button constants and the expected button sequence.
package jogo_pkg;

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        JOGAR     = 3'd1,
        ESPERA    = 3'd2,
        PRESSIONA = 3'd3,
        SOLTA     = 3'd4,
        PROXIMA   = 3'd5,
        FIM       = 3'd6
    } estado_t;

    localparam logic [3:0] BOTAO_0 = 4'b0001;
    localparam logic [3:0] BOTAO_1 = 4'b0010;
    localparam logic [3:0] BOTAO_2 = 4'b0100;
    localparam logic [3:0] BOTAO_3 = 4'b1000;

    localparam logic [3:0] ROM_SEQ [16] = '{
        BOTAO_0, BOTAO_1, BOTAO_2, BOTAO_3,
        BOTAO_0, BOTAO_1, BOTAO_2, BOTAO_3,
        BOTAO_0, BOTAO_1, BOTAO_2, BOTAO_3,
        BOTAO_0, BOTAO_1, BOTAO_2, BOTAO_3
    };

    // Rotating a one-hot pattern keeps it one-hot but never equal to the original.
    function automatic logic [3:0] rotl1(input logic [3:0] b);
        return {b[2:0], b[3]};
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sequencia_rom.sv
// Combinational 16x4 ROM holding the expected button for each play index.
module sequencia_rom
    import jogo_pkg::*;
(
    input  logic [3:0] endereco_i,
    output logic [3:0] dado_o
);

    assign dado_o = ROM_SEQ[endereco_i];

endmodule

// File: rtl/jogador_automatico.sv
// Automatic player for the memory game: pulses jogar, then replays the expected
// sequence round by round, with optional single-press error injection.
module jogador_automatico
    import jogo_pkg::*;
#(
    parameter int NUM_RODADAS  = 16,
    parameter int JOGAR_CYCLES = 5,
    parameter int START_WAIT   = 10,
    parameter int PRESS_CYCLES = 5,
    parameter int GAP_CYCLES   = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       erro_en,
    input  logic [3:0] erro_rodada,
    input  logic [3:0] erro_jogada,
    input  logic       ganhou,
    input  logic       perdeu,
    output logic       jogar,
    output logic [3:0] botoes,
    output logic       ativo,
    output logic       fim,
    output logic       resultado,
    output logic [3:0] db_rodada,
    output logic [2:0] db_estado
);

    localparam int MAX_P = max_int(max_int(JOGAR_CYCLES, START_WAIT),
                                   max_int(PRESS_CYCLES, GAP_CYCLES));
    localparam int TW = $clog2(MAX_P) + 1;

    localparam logic [TW-1:0] T_JOGAR  = TW'(JOGAR_CYCLES - 1);
    localparam logic [TW-1:0] T_ESPERA = TW'(START_WAIT - 1);
    localparam logic [TW-1:0] T_PRESS  = TW'(PRESS_CYCLES - 1);
    localparam logic [TW-1:0] T_SOLTA  = TW'(GAP_CYCLES - 1);
    localparam logic [3:0]    ULTIMA   = 4'(NUM_RODADAS - 1);

    estado_t       estado_q, estado_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    rodada_q, rodada_d;
    logic [3:0]    jogada_q, jogada_d;
    logic          jogar_q, jogar_d;
    logic [3:0]    botoes_q, botoes_d;
    logic          ativo_q, ativo_d;
    logic          fim_q, fim_d;
    logic          resultado_q, resultado_d;
    logic [3:0]    rom_dado;
    logic [3:0]    padrao;
    logic          chegou_fim;

    sequencia_rom u_rom (
        .endereco_i (jogada_d),
        .dado_o     (rom_dado)
    );

    assign chegou_fim = ganhou | perdeu;

    always_comb begin
        estado_d    = estado_q;
        timer_d     = (timer_q != '0) ? timer_q - 1'b1 : '0;
        rodada_d    = rodada_q;
        jogada_d    = jogada_q;
        resultado_d = resultado_q;

        unique case (estado_q)
            OCIOSO, FIM: begin
                if (iniciar) begin
                    estado_d    = JOGAR;
                    timer_d     = T_JOGAR;
                    rodada_d    = '0;
                    jogada_d    = '0;
                    resultado_d = 1'b0;
                end
            end
            JOGAR: begin
                if (timer_q == '0) begin
                    estado_d = ESPERA;
                    timer_d  = T_ESPERA;
                end
            end
            ESPERA, PRESSIONA, SOLTA, PROXIMA: begin
                // A verdict from the game overrides every sequencing decision.
                if (chegou_fim) begin
                    estado_d    = FIM;
                    timer_d     = '0;
                    resultado_d = ganhou;
                end else begin
                    unique case (estado_q)
                        ESPERA: begin
                            if (timer_q == '0) begin
                                estado_d = PRESSIONA;
                                timer_d  = T_PRESS;
                            end
                        end
                        PRESSIONA: begin
                            if (timer_q == '0) begin
                                estado_d = SOLTA;
                                timer_d  = T_SOLTA;
                            end
                        end
                        SOLTA: begin
                            if (timer_q == '0) begin
                                estado_d = PROXIMA;
                                timer_d  = '0;
                            end
                        end
                        default: begin
                            if (jogada_q < rodada_q) begin
                                estado_d = PRESSIONA;
                                timer_d  = T_PRESS;
                                jogada_d = jogada_q + 4'd1;
                            end else if (rodada_q < ULTIMA) begin
                                estado_d = PRESSIONA;
                                timer_d  = T_PRESS;
                                rodada_d = rodada_q + 4'd1;
                                jogada_d = '0;
                            end else begin
                                estado_d    = FIM;
                                timer_d     = '0;
                                resultado_d = 1'b0;
                            end
                        end
                    endcase
                end
            end
            default: begin
                estado_d = OCIOSO;
                timer_d  = '0;
            end
        endcase
    end

    // Outputs are derived from the next state so they register in step with it.
    always_comb begin
        padrao = rom_dado;
        if (erro_en && (rodada_d == erro_rodada) && (jogada_d == erro_jogada)) begin
            padrao = rotl1(rom_dado);
        end
        jogar_d  = (estado_d == JOGAR);
        botoes_d = (estado_d == PRESSIONA) ? padrao : 4'b0000;
        ativo_d  = (estado_d != OCIOSO) && (estado_d != FIM);
        fim_d    = (estado_d == FIM);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q    <= OCIOSO;
            timer_q     <= '0;
            rodada_q    <= '0;
            jogada_q    <= '0;
            jogar_q     <= 1'b0;
            botoes_q    <= '0;
            ativo_q     <= 1'b0;
            fim_q       <= 1'b0;
            resultado_q <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            timer_q     <= timer_d;
            rodada_q    <= rodada_d;
            jogada_q    <= jogada_d;
            jogar_q     <= jogar_d;
            botoes_q    <= botoes_d;
            ativo_q     <= ativo_d;
            fim_q       <= fim_d;
            resultado_q <= resultado_d;
        end
    end

    assign jogar     = jogar_q;
    assign botoes    = botoes_q;
    assign ativo     = ativo_q;
    assign fim       = fim_q;
    assign resultado = resultado_q;
    assign db_rodada = rodada_q;
    assign db_estado = estado_q;

endmodule
